// File: rtl/fb_pkg.sv
// fb_pkg: shared types and sizes for the subband frame serializer
package fb_pkg;
  localparam int NUM_BANDS = 16;
  localparam int DATA_W = 29;
  localparam int BAND_IDX_W = $clog2(NUM_BANDS);
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [NUM_BANDS-1:0] band_vec_t;
  typedef enum logic [1:0] {EMPTY, FULL, ACTIVE} bank_state_t;
  typedef enum logic {IDLE, STREAM} ser_state_t;
endpackage

// File: rtl/subband_frame_bank.sv
// subband_frame_bank: one frame of band samples with load enable and indexed read
module subband_frame_bank
  import fb_pkg::*;
(
  input  logic                        clk_en,
  input  logic                        load,
  input  logic [NUM_BANDS*DATA_W-1:0] din,
  input  logic [BAND_IDX_W-1:0]       rd_idx,
  output logic [DATA_W-1:0]           rd_data
);
  band_vec_t mem_q;
  // Latch the whole parallel frame when this bank is chosen for capture
  always_ff @(posedge clk_en)
    if (load) mem_q <= din;
  assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/subband_frame_serializer.sv
// subband_frame_serializer: ping-pong frame capture streamed one band per beat
module subband_frame_serializer
  import fb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                        clk_en,
  input  logic                        reset,
  input  logic [NUM_BANDS*DATA_W-1:0] band_in,
  input  logic                        band_strobe,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [BAND_IDX_W-1:0]       out_band,
  output logic                        out_last,
  output logic                        overrun,
  output logic [CNT_W-1:0]            frame_count,
  output logic [CNT_W-1:0]            drop_count
);
  ser_state_t state_q, state_d;
  bank_state_t bank_q [2];
  bank_state_t bank_d [2];
  bank_state_t eff [2];
  logic act_q, act_d, valid_q, valid_d, last_q, last_d, ovr_q, ovr_d;
  logic [BAND_IDX_W-1:0] band_q, band_d, rd_idx;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rd_data [2];
  logic [CNT_W-1:0] fc_q, fc_d, dc_q, dc_d;
  logic xfer, fin, cap_ok, cap_sel, go, nb;
  logic [1:0] load;

  for (genvar i = 0; i < 2; i++) begin : g_bank
    subband_frame_bank u_bank (
      .clk_en (clk_en),
      .load   (load[i]),
      .din    (band_in),
      .rd_idx (rd_idx),
      .rd_data(rd_data[i])
    );
  end

  // Bank bookkeeping, capture/drop decision and beat sequencing; a bank freed
  // by the final beat is already seen as EMPTY by a capture on the same edge
  always_comb begin
    xfer = valid_q & out_ready;
    fin = xfer & last_q;
    eff[0] = (fin && !act_q) ? EMPTY : bank_q[0];
    eff[1] = (fin && act_q) ? EMPTY : bank_q[1];
    cap_sel = eff[0] != EMPTY;
    cap_ok = band_strobe && (eff[0] == EMPTY || eff[1] == EMPTY);
    load = {cap_ok & cap_sel, cap_ok & ~cap_sel};
    nb = (state_q == IDLE) ? bank_q[0] != FULL : !act_q;
    go = (state_q == IDLE) ? (bank_q[0] == FULL || bank_q[1] == FULL)
                           : (fin && bank_q[!act_q] == FULL);
    rd_idx = go ? '0 : band_q + 1'b1;
    bank_d = eff;
    if (load[0]) bank_d[0] = FULL;
    if (load[1]) bank_d[1] = FULL;
    if (go) bank_d[nb] = ACTIVE;
    state_d = go ? STREAM : fin ? IDLE : state_q;
    act_d = go ? nb : act_q;
    valid_d = go | (valid_q & ~fin);
    band_d = go ? '0 : xfer ? band_q + 1'b1 : band_q;
    data_d = (go | (xfer & ~fin)) ? rd_data[go ? nb : act_q] : data_q;
    last_d = go ? 1'b0 : xfer ? band_q == BAND_IDX_W'(NUM_BANDS - 2) : last_q;
    fc_d = fc_q + CNT_W'(fin);
    dc_d = (band_strobe && !cap_ok && !(&dc_q)) ? dc_q + 1'b1 : dc_q;
    ovr_d = ovr_q | (band_strobe & ~cap_ok);
  end

  // State registers; reset discards any in-flight or pending frame
  always_ff @(posedge clk_en) begin
    if (reset) begin
      state_q <= IDLE;
      bank_q <= '{EMPTY, EMPTY};
      act_q <= 1'b0;
      valid_q <= 1'b0;
      band_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      ovr_q <= 1'b0;
      fc_q <= '0;
      dc_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      act_q <= act_d;
      valid_q <= valid_d;
      band_q <= band_d;
      data_q <= data_d;
      last_q <= last_d;
      ovr_q <= ovr_d;
      fc_q <= fc_d;
      dc_q <= dc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_band = band_q;
  assign out_last = last_q;
  assign overrun = ovr_q;
  assign frame_count = fc_q;
  assign drop_count = dc_q;
endmodule
